// File: rtl/intc_pkg.sv
// Shared definitions for the MIO interrupt controller: register map,
// FSM states, CTRL/EOI bit positions and a one-hot to index helper.
package intc_pkg;

  localparam int INTC_N_SRC = 5;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  localparam int CTRL_GIE_BIT    = 0;
  localparam int CTRL_INSERV_BIT = 1;
  localparam int CTRL_GNT_LSB    = 8;
  localparam int EOI_VALID_BIT   = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } intc_state_e;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (oh[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/intc_sync.sv
// Per-source two-flop synchronizer. With INTC_EDGE_EN defined the output is a
// one-cycle rising-edge pulse, otherwise it is the synchronized level.
module intc_sync
  import intc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq_raw,
  output logic irq_evt
);

  logic meta_r;
  logic sync_r;

  // metastability filter on the asynchronous device line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= irq_raw;
      sync_r <= meta_r;
    end
  end

`ifdef INTC_EDGE_EN
  logic sync_d_r;

  // previous synchronized level for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_d_r <= 1'b0;
    end else begin
      sync_d_r <= sync_r;
    end
  end

  assign irq_evt = sync_r & ~sync_d_r;
`else
  assign irq_evt = sync_r;
`endif

endmodule

// File: rtl/mio_int_ctrl.sv
// MIO-bus interrupt controller: PEND/MASK/CTRL/EOI registers, fixed-priority
// grant and Ireq/Iack/EOI handshake. Define INTC_EDGE_EN for edge-latched PEND.
module mio_int_ctrl
  import intc_pkg::*;
#(
  parameter int N_SRC = INTC_N_SRC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             stb,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic             Ireq,
  input  logic             Iack,
  output logic [N_SRC-1:0] gntInt
);

  logic [N_SRC-1:0] evt_s;
  logic [N_SRC-1:0] pend_r;
  logic [N_SRC-1:0] mask_r;
  logic             gie_r;
  logic [N_SRC-1:0] eligible_s;
  logic [N_SRC-1:0] winner_s;
  logic [N_SRC-1:0] gnt_r;
  logic [N_SRC-1:0] gnt_n_s;
  logic             ireq_r;
  logic             ireq_n_s;
  intc_state_e      state_r;
  intc_state_e      state_n_s;
  logic             ready_r;
  logic [31:0]      rdata_r;
  logic [31:0]      rd_val_s;
  logic             access_s;
  logic             wr_s;
  logic             rd_s;
  logic             eoi_wr_s;
  logic [7:0]       gnt_ext_s;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    intc_sync u_sync (
      .clk     (clk),
      .reset   (reset),
      .irq_raw (irq_src[i]),
      .irq_evt (evt_s[i])
    );
  end

  // An access happens on the first edge of stb; the ready cycle blocks a repeat.
  assign access_s  = stb & ~ready_r;
  assign wr_s      = access_s & we;
  assign rd_s      = access_s & ~we;
  assign eoi_wr_s  = wr_s & (addr == REG_EOI);
  assign gnt_ext_s = 8'(gnt_r);

`ifdef INTC_EDGE_EN
  logic [N_SRC-1:0] pend_clr_s;

  assign pend_clr_s = ((wr_s && (addr == REG_PEND)) ? wdata[N_SRC-1:0] : {N_SRC{1'b0}})
                    | (((state_r == REQ) && Iack) ? gnt_r : {N_SRC{1'b0}});

  // pending latch: a fresh edge beats a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r <= {N_SRC{1'b0}};
    end else begin
      pend_r <= (pend_r & ~pend_clr_s) | evt_s;
    end
  end
`else
  // pending follows the synchronized line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r <= {N_SRC{1'b0}};
    end else begin
      pend_r <= evt_s;
    end
  end
`endif

  // MASK and GIE configuration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r <= {N_SRC{1'b0}};
      gie_r  <= 1'b0;
    end else begin
      if (wr_s && (addr == REG_MASK)) begin
        mask_r <= wdata[N_SRC-1:0];
      end
      if (wr_s && (addr == REG_CTRL)) begin
        gie_r <= wdata[CTRL_GIE_BIT];
      end
    end
  end

  assign eligible_s = pend_r & mask_r & {N_SRC{gie_r}};
  // isolate the lowest set bit: highest priority eligible source
  assign winner_s   = eligible_s & (~eligible_s + N_SRC'(1'b1));

  // grant FSM next state; grant is frozen from REQ until EOI
  always_comb begin
    state_n_s = state_r;
    ireq_n_s  = ireq_r;
    gnt_n_s   = gnt_r;
    case (state_r)
      IDLE: begin
        if (|eligible_s) begin
          gnt_n_s   = winner_s;
          ireq_n_s  = 1'b1;
          state_n_s = REQ;
        end else begin
          state_n_s = IDLE;
        end
      end
      REQ: begin
        if (Iack) begin
          ireq_n_s  = 1'b0;
          state_n_s = SERV;
        end else begin
          state_n_s = REQ;
        end
      end
      SERV: begin
        if (eoi_wr_s) begin
          gnt_n_s   = {N_SRC{1'b0}};
          state_n_s = IDLE;
        end else begin
          state_n_s = SERV;
        end
      end
      default: begin
        state_n_s = IDLE;
        ireq_n_s  = 1'b0;
        gnt_n_s   = {N_SRC{1'b0}};
      end
    endcase
  end

  // grant FSM state and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      ireq_r  <= 1'b0;
      gnt_r   <= {N_SRC{1'b0}};
    end else begin
      state_r <= state_n_s;
      ireq_r  <= ireq_n_s;
      gnt_r   <= gnt_n_s;
    end
  end

  // register read mux
  always_comb begin
    rd_val_s = 32'h0000_0000;
    case (addr)
      REG_PEND: rd_val_s[N_SRC-1:0] = pend_r;
      REG_MASK: rd_val_s[N_SRC-1:0] = mask_r;
      REG_CTRL: begin
        rd_val_s[CTRL_GIE_BIT]        = gie_r;
        rd_val_s[CTRL_INSERV_BIT]     = (state_r == SERV);
        rd_val_s[CTRL_GNT_LSB +: 8]   = gnt_ext_s;
      end
      REG_EOI: begin
        rd_val_s[EOI_VALID_BIT] = |gnt_r;
        rd_val_s[2:0]           = onehot_to_idx(gnt_ext_s);
      end
      default: rd_val_s = 32'h0000_0000;
    endcase
  end

  // bus response: one-cycle ready, rdata only meaningful alongside it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_r <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      ready_r <= access_s;
      rdata_r <= rd_s ? rd_val_s : 32'h0000_0000;
    end
  end

  assign rdata  = rdata_r;
  assign ready  = ready_r;
  assign Ireq   = ireq_r;
  assign gntInt = gnt_r;

endmodule
